serial_subtractor_ctrl: RTL and testbench

Bit-serial N-bit unsigned subtractor controller that computes diff = a - b.
It reuses a single 1-bit subtract cell over WIDTH cycles, feeding operands LSB-first and holding the borrow in a flip-flop between bits.
A start/busy/done handshake lets higher-level blocks use one small subtract cell in place of a WIDTH-bit parallel subtractor.

---
 rtl/subtractor_pkg.sv | 14 +
 rtl/full_subtractor.sv | 33 +++
 rtl/half_subtractor.sv | 12 +
 rtl/serial_subtractor_ctrl.sv | 106 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package subtractor_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  // Encoding 2'd3 is unused; the controller decodes it as IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor built from two half subtractors.
// The first stage subtracts y from x; the second subtracts the incoming
// borrow from that partial difference. At most one stage can borrow, so
// OR-ing the two borrows gives the outgoing borrow.
module full_subtractor (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_subtractor u_hs_xy (
    .i_x    (i_x),
    .i_y    (i_y),
    .o_d    (w_d1),
    .o_bout (w_b1)
  );

  half_subtractor u_hs_bin (
    .i_x    (w_d1),
    .i_y    (i_bin),
    .o_d    (o_d),
    .o_bout (w_b2)
  );

  assign o_bout = w_b1 | w_b2;

endmodule

// File: rtl/half_subtractor.sv
// Combinational 1-bit half subtractor: d = x - y, bout set when y > x.
module half_subtractor (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_x ^ i_y;
  assign o_bout = ~i_x & i_y;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor (diff = a - b). One full
// subtractor cell is reused over WIDTH cycles, operands fed LSB-first with
// the borrow held in a flip-flop between bits. start/busy/done handshake;
// a start during the done cycle is accepted for back-to-back operation.
module serial_subtractor_ctrl
  import subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_count;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_cell (
    .i_x    (r_a_sh[0]),
    .i_y    (r_b_sh[0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // Result register after this bit: new difference bit enters at the MSB so
  // that after WIDTH shifts bit 0 of the result sits at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_d;
    end else begin : g_res_wn
      assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM with datapath and registered handshake outputs.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res      <= '0;
      r_borrow   <= 1'b0;
      r_count    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          r_res    <= w_res_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_borrow <= w_bout;
          if (r_count == LAST_BIT) begin
            r_state    <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= w_res_next;
            borrow_out <= w_bout;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        // IDLE and DONE accept a start identically; the unused encoding
        // falls in here too so a corrupted state recovers as IDLE.
        default: begin
          done <= 1'b0;
          if (start) begin
            r_state  <= SHIFT;
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= 1'b0;
            r_count  <= '0;
            busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: a WIDTH=8 and a WIDTH=1
// instance, directed cases plus random operands checked against plain
// arithmetic (a - b mod 2^W, borrow = a < b).
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, bo8;
  logic       start1, a1, b1, busy1, done1, diff1, bo1;

  int checks   = 0;
  int failures = 0;

  // Model of the held outputs of the 8-bit instance.
  logic [7:0] m_diff;
  logic       m_bo;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one 8-bit operation whose launching start is already driven.
  // glitch_at: cycle index at which a spurious start is pulsed (0 = none).
  // chain: keep start high and present na/nb so DONE accepts the next op.
  task automatic finish8(input logic [7:0] a, input logic [7:0] b, input int glitch_at,
                         input bit chain, input logic [7:0] na, input logic [7:0] nb);
    logic [7:0] ed;
    logic       eb;
    int         lat;
    bit         busy_ok;
    bit         hold_ok;
    ed      = a - b;
    eb      = (a < b);
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    @(negedge clk);
    start8 = chain;
    a8     = chain ? na : 8'($urandom);
    b8     = chain ? nb : 8'($urandom);
    lat    = 1;
    while (!done8 && lat < 40) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      if (diff8 !== m_diff || bo8 !== m_bo) hold_ok = 1'b0;
      if (!chain) begin
        start8 = (lat == glitch_at);
        if (start8) begin
          a8 = 8'h01;
          b8 = 8'h01;
        end
      end
      @(negedge clk);
      lat++;
    end
    check("latency8", lat, 9);
    check("diff8", diff8, ed);
    check("borrow8", bo8, eb);
    check("busy_in_done8", busy8, 0);
    check("busy_during_shift8", busy_ok, 1);
    check("outputs_held_during_shift8", hold_ok, 1);
    m_diff = ed;
    m_bo   = eb;
    if (!chain) begin
      start8 = 1'b0;
      @(negedge clk);
      check("done_single_pulse8", done8, 0);
      check("idle_after_done8", busy8, 0);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int glitch_at,
                     input bit chain, input logic [7:0] na, input logic [7:0] nb);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    finish8(a, b, glitch_at, chain, na, nb);
  endtask

  task automatic op1(input logic a, input logic b);
    int lat;
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    @(negedge clk);
    start1 = 1'b0;
    a1     = ~a;
    b1     = ~b;
    check("busy1", busy1, 1);
    lat = 1;
    while (!done1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency1", lat, 2);
    check("diff1", diff1, a ^ b);
    check("borrow1", bo1, (!a && b));
    @(negedge clk);
    check("done_single_pulse1", done1, 0);
  endtask

  initial begin
    bit no_done;
    rst    = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    m_diff = '0;
    m_bo   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_diff8", diff8, 0);
    check("rst_borrow8", bo8, 0);
    check("rst_busy1", busy1, 0);
    check("rst_diff1", diff1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operands, including borrow and equal-operand boundaries.
    op8(8'h35, 8'h12, 0, 1'b0, 8'h00, 8'h00);
    op8(8'h12, 8'h35, 0, 1'b0, 8'h00, 8'h00);
    op8(8'h00, 8'h01, 0, 1'b0, 8'h00, 8'h00);
    op8(8'hFF, 8'hFF, 0, 1'b0, 8'h00, 8'h00);

    // Start pulsed mid-SHIFT must be ignored; no second done afterwards.
    op8(8'hA7, 8'h3C, 3, 1'b0, 8'h00, 8'h00);
    no_done = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) no_done = 1'b0;
    end
    check("ignored_start_no_second_op", no_done, 1);

    // Back-to-back: start held through DONE launches the next op at once.
    op8(8'h35, 8'h12, 0, 1'b1, 8'h80, 8'h7F);
    finish8(8'h80, 8'h7F, 0, 1'b0, 8'h00, 8'h00);

    // Reset four cycles into SHIFT aborts with cleared outputs.
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h0F;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy8", busy8, 0);
    check("abort_done8", done8, 0);
    check("abort_diff8", diff8, 0);
    check("abort_borrow8", bo8, 0);
    m_diff = '0;
    m_bo   = 1'b0;
    no_done = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 !== 1'b0) no_done = 1'b0;
    end
    check("abort_no_done8", no_done, 1);
    op8(8'h5A, 8'h0F, 0, 1'b0, 8'h00, 8'h00);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 0, 1'b0, 8'h00, 8'h00);
    end

    // Single-bit instance.
    op1(1'b0, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b1, 1'b1);
    op1(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
